// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding and
// the width rule for the received-bit counter.
package serial_frame_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } rx_state_e;

    // Counter must be able to hold the value SIZE itself, not just SIZE-1.
    function automatic int bit_count_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/serial_frame_receiver_bit_synchronizer.sv
// Multi-flop synchroniser bringing one asynchronous pin into the clk domain.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the pin value through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/serial_frame_receiver.sv
// SPI-style serial front end: synchronises the link, strobes bits into the
// downstream SIPO and hands complete frames over with valid/ready.
module serial_frame_receiver
    import serial_frame_receiver_pkg::*;
#(
    parameter int SIZE        = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sclk,
    input  logic                              cs_n,
    input  logic                              sdi,
    output logic                              shift,
    output logic                              s_in,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [bit_count_width(SIZE)-1:0]  bit_count,
    output logic                              frame_abort,
    output logic                              overrun
);

    localparam int            CW       = bit_count_width(SIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic      sclk_sync_s;
    logic      cs_n_sync_s;
    logic      sdi_sync_s;
    logic      sclk_prev_r;
    logic      rise_s;
    rx_state_e state_r;

    bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .d     (sclk),
        .q     (sclk_sync_s)
    );

    bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clk   (clk),
        .reset (reset),
        .d     (cs_n),
        .q     (cs_n_sync_s)
    );

    // sdi goes through the same depth so it lines up with the detected edge.
    bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk   (clk),
        .reset (reset),
        .d     (sdi),
        .q     (sdi_sync_s)
    );

    // Delayed copy of synchronised sclk for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_prev_r <= sclk_sync_s;
        end
    end

    assign rise_s = sclk_sync_s & ~sclk_prev_r;

    // Frame FSM with bit counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shift       <= 1'b0;
            s_in        <= 1'b0;
            frame_valid <= 1'b0;
            bit_count   <= '0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            shift       <= 1'b0;
            frame_abort <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    frame_valid <= 1'b0;
                    bit_count   <= '0;
                    if (!cs_n_sync_s) begin
                        state_r <= ST_RECV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    frame_valid <= 1'b0;
                    // A deselect beats a coincident clock edge: the bit is discarded.
                    if (cs_n_sync_s) begin
                        if (bit_count != '0) begin
                            frame_abort <= 1'b1;
                        end else begin
                            frame_abort <= 1'b0;
                        end
                        bit_count <= '0;
                        state_r   <= ST_IDLE;
                    end else if (rise_s) begin
                        shift     <= 1'b1;
                        s_in      <= sdi_sync_s;
                        bit_count <= bit_count + ONE;
                        if (bit_count == LAST_BIT) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_RECV;
                        end
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                ST_HOLD: begin
                    // Any edge while the frame is still pending is lost.
                    if (rise_s && !cs_n_sync_s) begin
                        overrun <= 1'b1;
                    end else begin
                        overrun <= overrun;
                    end
                    if (frame_valid && frame_ready) begin
                        frame_valid <= 1'b0;
                        bit_count   <= '0;
                        if (!cs_n_sync_s) begin
                            state_r <= ST_RECV;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        frame_valid <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    frame_valid <= 1'b0;
                    bit_count   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Serial front end that sits directly upstream of the SIPO shift register. It synchronises an external SPI-style serial link (sclk, cs_n, sdi) into the system clock domain and converts each sclk rising edge into a one-cycle shift/s_in strobe for the SIPO. It counts bits, flags a complete SIZE-bit frame to the downstream consumer with a valid/ready handshake, and reports aborted frames and overruns.

## Interface
- SIZE, 256, frame length in bits; must match the SIPO SIZE
- SYNC_STAGES, 2, synchroniser depth (≥2) for sclk, cs_n, sdi
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sclk  in  1  external serial clock, asynchronous to clk; max frequency clk/4
- cs_n  in  1  external frame select, active low, asynchronous
- sdi  in  1  external serial data, MSB first, stable around sclk rising edge
- shift  out  1  one-cycle strobe to SIPO shift input
- s_in  out  1  serial bit to SIPO s_in; meaningful only while shift=1
- frame_valid  out  1  SIPO p_out holds a complete frame
- frame_ready  in  1  consumer has taken the frame
- bit_count  out  $clog2(SIZE+1)  bits received in the current frame
- frame_abort  out  1  one-cycle pulse: cs_n deasserted mid-frame
- overrun  out  1  sticky: sclk edge arrived while a frame was pending

## Operation
- sclk, cs_n, sdi each pass through SYNC_STAGES flops; one further register on synced sclk gives rising-edge detect (rise = sync & ~prev). sdi uses the same depth, so sdi sampled with rise is aligned to the pin-level edge.
- FSM states IDLE, RECV, HOLD; reset → IDLE.
- IDLE: bit_count=0, no strobes. Synced cs_n low → RECV.
- RECV, synced cs_n low, rise: shift=1, s_in=synced sdi, bit_count+1. If this is bit SIZE → HOLD.
- RECV, synced cs_n high: if bit_count>0 pulse frame_abort; bit_count←0; → IDLE. cs_n high wins over a simultaneous rise (bit discarded, no shift).
- HOLD: frame_valid=1, shift=0. rise (cs_n low) → overrun←1, bit dropped, stay HOLD. cs_n changes are ignored for state. frame_valid & frame_ready → bit_count←0; → RECV if synced cs_n low, else IDLE.
- overrun cleared only by reset.
- bit_count never exceeds SIZE; no wrap.
- Reset values: shift=0, s_in=0, frame_valid=0, bit_count=0, frame_abort=0, overrun=0, all sync flops 0, state IDLE. Reset mid-frame discards partial frame; SIPO is reset by the same reset.

## Timing
- All outputs registered.
- sclk pin rise → shift high: SYNC_STAGES+1 clk cycles (3 at default); shift width exactly 1 cycle.
- Final shift at cycle N → SIPO p_out complete at the same edge → frame_valid high from cycle N+1.
- Handshake completes on the edge where frame_valid & frame_ready; frame_valid low the following cycle; earliest next shift one cycle after that.
- frame_ready while frame_valid=0 is ignored.
- frame_abort asserted the cycle after synced cs_n observed high in RECV.

## Structure
- Shared package/header: FSM state encoding (IDLE/RECV/HOLD), bit_count width function.
- One sub-module: bit_synchronizer (parameter SYNC_STAGES, async reset to 0), instantiated three times for sclk, cs_n, sdi.
- Edge detect, counter, FSM in the top module; no other hierarchy.

## Test plan
Run with SIZE=8 (plus one pass at 256), SIPO instantiated downstream, sclk = clk/8.
- Reset: hold reset 5 cycles with sclk toggling → every output 0, no shift pulses.
- Single frame 0xA5, frame_ready=0 → 8 shift pulses, s_in 1,0,1,0,0,1,0,1; frame_valid rises one cycle after 8th shift; SIPO p_out=0xA5; bit_count=8.
- Backpressure: after frame, 2 more sclk edges with frame_ready=0 → overrun=1, no shift, p_out still 0xA5; then frame_ready=1 → frame_valid drops next cycle, overrun stays 1.
- Abort: cs_n high after 3 bits → one frame_abort pulse, bit_count=0, no frame_valid; next full frame 0x3C received correctly.
- Back-to-back: frame_ready tied 1, cs_n low, 16 bits → frames 0x3C then 0xC3, each frame_valid high exactly one cycle, no bits lost, overrun=0.
- Reset mid-frame after 5 bits → outputs to reset values; following frame 0xFF captured as 0xFF.
